// File: rtl/morse_round_ctrl.sv
// morse_round_ctrl: Morse game round controller that generates a pseudo-random digit
// sequence, shows each digit for HOLD_CYCLES, then collects answers and keeps a BCD score.
module morse_round_ctrl #(
    parameter int         SEQ_LEN     = 3,
    parameter int         HOLD_CYCLES = 150_000_000,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       logged_in,
    input  logic       game_start,
    input  logic       load,
    input  logic [3:0] user_input,
    input  logic       timeout,
    input  logic       logout,
    output logic       reconfig,
    output logic       enable,
    output logic [3:0] number,
    output logic [3:0] score_ones,
    output logic [3:0] score_tens,
    output logic       correct,
    output logic       logout_from_gamecontrol
);
    localparam int IW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int CW = $clog2(HOLD_CYCLES);
    localparam logic [IW-1:0] LAST = IW'(SEQ_LEN - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, READY, GEN, SHOW, ANSWER, RESULT} state_t;

    state_t        r_state, w_next;
    logic [7:0]    r_lfsr;
    logic [3:0]    r_seq [SEQ_LEN];
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic [3:0]    w_digit;
    logic          w_last_idx, w_hold_done, w_load_last, w_mismatch, w_logout;

    assign w_digit     = (r_lfsr[3:0] >= 4'd10) ? r_lfsr[3:0] - 4'd10 : r_lfsr[3:0];
    assign w_last_idx  = (r_idx == LAST);
    assign w_hold_done = (r_cnt == HOLD_LAST);
    assign w_load_last = load && w_last_idx;
    assign w_mismatch  = load && (user_input != r_seq[r_idx]);
    assign w_logout    = logout && (r_state != IDLE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = logged_in ? READY : IDLE;
            READY:   w_next = game_start ? GEN : (logged_in ? READY : IDLE);
            GEN:     w_next = w_last_idx ? SHOW : GEN;
            SHOW:    w_next = (w_hold_done && w_last_idx) ? ANSWER : SHOW;
            ANSWER:  w_next = (w_load_last || timeout) ? RESULT : ANSWER;
            RESULT:  w_next = READY;
            default: w_next = IDLE;
        endcase
        if (w_logout) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr                  <= LFSR_SEED;
            r_idx                   <= '0;
            r_cnt                   <= '0;
            r_err                   <= 1'b0;
            reconfig                <= 1'b0;
            enable                  <= 1'b0;
            number                  <= 4'd0;
            score_ones              <= 4'd0;
            score_tens              <= 4'd0;
            correct                 <= 1'b0;
            logout_from_gamecontrol <= 1'b0;
            for (int i = 0; i < SEQ_LEN; i++) r_seq[i] <= 4'd0;
        end else begin
            r_lfsr                  <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            reconfig                <= 1'b0;
            correct                 <= 1'b0;
            logout_from_gamecontrol <= 1'b0;
            enable                  <= (w_next == ANSWER);
            if (w_logout) begin
                logout_from_gamecontrol <= 1'b1;
                score_ones              <= 4'd0;
                score_tens              <= 4'd0;
                number                  <= 4'd0;
                r_idx                   <= '0;
                r_cnt                   <= '0;
            end else begin
                case (r_state)
                    READY: begin
                        r_idx <= '0;
                        r_cnt <= '0;
                    end
                    GEN: begin
                        r_seq[r_idx] <= w_digit;
                        r_idx        <= w_last_idx ? '0 : r_idx + 1'b1;
                        if (w_last_idx) begin
                            // a single-digit round has only just captured its digit this cycle
                            number   <= (r_idx == '0) ? w_digit : r_seq[0];
                            reconfig <= 1'b1;
                            r_cnt    <= '0;
                        end
                    end
                    SHOW: begin
                        if (!w_hold_done) r_cnt <= r_cnt + 1'b1;
                        else if (w_last_idx) begin
                            r_cnt  <= '0;
                            r_idx  <= '0;
                            number <= 4'd0;
                            r_err  <= 1'b0;
                        end else begin
                            r_cnt    <= '0;
                            r_idx    <= r_idx + 1'b1;
                            number   <= r_seq[r_idx + 1'b1];
                            reconfig <= 1'b1;
                        end
                    end
                    ANSWER: begin
                        if (load) r_idx <= r_idx + 1'b1;
                        if (w_mismatch || (timeout && !w_load_last)) r_err <= 1'b1;
                    end
                    RESULT: begin
                        if (!r_err) begin
                            correct <= 1'b1;
                            if (score_ones != 4'd9) score_ones <= score_ones + 4'd1;
                            else if (score_tens != 4'd9) begin
                                score_ones <= 4'd0;
                                score_tens <= score_tens + 4'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
